// File: rtl/fpadd_pkg.sv
// Shared definitions for the shared floating-point adder controller.
//   DW      : operand / result width (IEEE-754 single)
//   LATENCY : external adder latency in clock edges
//   ID_W    : requester identifier width
//   tag_t   : per-stage ownership tag travelling alongside the adder pipeline
package fpadd_pkg;
    localparam int DW      = 32;
    localparam int LATENCY = 7;
    localparam int ID_W    = 1;

    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/fpadd_rsp_fifo.sv
// Synchronous response FIFO, DEPTH x DW, asynchronous active-low clear.
//   push/din  : write an entry (ignored when full)
//   pop/dout  : dout shows the head; pop removes it (ignored when empty)
//   empty/full/count : occupancy status, count is one bit wider than the pointers
// A push is visible on dout no earlier than the cycle after it is written.
module fpadd_rsp_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign do_push_s = push && (count_q != FULL_CNT);
    assign do_pop_s  = pop && (count_q != '0);

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;
endmodule

// Checker: a push into a full FIFO means the credit accounting is broken.
module fpadd_rsp_fifo_chk (
    input logic clk,
    input logic clear_n,
    input logic push,
    input logic full
);
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!clear_n) !(push && full));
endmodule

// File: rtl/fpadd_share_ctrl.sv
// Shares one external pipelined FP adder between two requesters.
//   req0_*/req1_* : operand pairs in, valid/ready handshake (ready = grant)
//   add_a/add_b   : operands to the adder (0 when nothing is granted)
//   add_res       : adder sum, aligned with the last tag pipeline stage
//   rsp0_*/rsp1_* : per-requester result FIFOs, valid/ready handshake
//   busy          : any tagged operation in flight or any FIFO non-empty
// Credits (in-flight + queued per requester) stop issue once the requester's FIFO
// could not absorb every outstanding result, so a result is never dropped.
module fpadd_share_ctrl #(
    parameter int LATENCY = fpadd_pkg::LATENCY,
    parameter int DW      = fpadd_pkg::DW,
    parameter int DEPTH   = 8
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic [DW-1:0] add_a,
    output logic [DW-1:0] add_b,
    input  logic [DW-1:0] add_res,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [DW-1:0] rsp0_data,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp1_data,
    output logic          busy
);
    import fpadd_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [CW-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic            last_q, last_d;   // id of the most recent grant
    tag_t            tag_q [LATENCY];
    logic            elig0_s, elig1_s, grant0_s, grant1_s, grant_any_s;
    logic [ID_W-1:0] gid_s;
    logic            rsp0_hs_s, rsp1_hs_s, push0_s, push1_s;
    logic            empty0_s, empty1_s, full0_s, full1_s;
    logic [AW:0]     count0_s, count1_s;
    logic [DW-1:0]   dout0_s, dout1_s;

    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c, input logic inc,
                                               input logic dec);
        logic [CW-1:0] r;
        case ({inc, dec})
            2'b10:   r = c + 1'b1;
            2'b01:   r = c - 1'b1;
            default: r = c;
        endcase
        return r;
    endfunction

    // Eligibility, round-robin grant and operand steering. Grants are gated by
    // clear_n so every output holds its reset value while reset is asserted.
    always_comb begin
        elig0_s  = clear_n && req0_valid && (cnt0_q < CNT_MAX);
        elig1_s  = clear_n && req1_valid && (cnt1_q < CNT_MAX);
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (elig0_s && elig1_s) begin
            if (last_q) grant0_s = 1'b1;
            else        grant1_s = 1'b1;
        end else begin
            grant0_s = elig0_s;
            grant1_s = elig1_s;
        end
        grant_any_s = grant0_s || grant1_s;
        gid_s       = grant1_s;
        last_d      = grant_any_s ? grant1_s : last_q;
        if (grant1_s) begin
            add_a = req1_a;
            add_b = req1_b;
        end else if (grant0_s) begin
            add_a = req0_a;
            add_b = req0_b;
        end else begin
            add_a = '0;
            add_b = '0;
        end
    end

    // Credit updates and result steering from the stage aligned with add_res.
    always_comb begin
        rsp0_hs_s = !empty0_s && rsp0_ready;
        rsp1_hs_s = !empty1_s && rsp1_ready;
        cnt0_d    = cnt_next(cnt0_q, grant0_s, rsp0_hs_s);
        cnt1_d    = cnt_next(cnt1_q, grant1_s, rsp1_hs_s);
        push0_s   = tag_q[LATENCY-1].v && (tag_q[LATENCY-1].id == 1'b0);
        push1_s   = tag_q[LATENCY-1].v && (tag_q[LATENCY-1].id == 1'b1);
    end

    // Credit counters, round-robin pointer and the ownership tag shift register.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
            last_q <= 1'b1;
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
        end else begin
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
            last_q   <= last_d;
            tag_q[0] <= '{v: grant_any_s, id: gid_s};
            for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    fpadd_rsp_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .clear_n(clear_n), .push(push0_s), .din(add_res), .pop(rsp0_hs_s),
        .dout(dout0_s), .empty(empty0_s), .full(full0_s), .count(count0_s)
    );

    fpadd_rsp_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .clear_n(clear_n), .push(push1_s), .din(add_res), .pop(rsp1_hs_s),
        .dout(dout1_s), .empty(empty1_s), .full(full1_s), .count(count1_s)
    );

    fpadd_rsp_fifo_chk u_chk0 (.clk(clk), .clear_n(clear_n), .push(push0_s), .full(full0_s));
    fpadd_rsp_fifo_chk u_chk1 (.clk(clk), .clear_n(clear_n), .push(push1_s), .full(full1_s));

    // Busy comes only from registered state: tag valids and FIFO occupancy.
    always_comb begin
        busy = (count0_s != '0) || (count1_s != '0);
        for (int i = 0; i < LATENCY; i++) busy = busy | tag_q[i].v;
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign rsp0_valid = !empty0_s;
    assign rsp1_valid = !empty1_s;
    assign rsp0_data  = dout0_s;
    assign rsp1_data  = dout1_s;
endmodule

// File: tb/tb_fpadd_share_ctrl.sv
module tb_fpadd_share_ctrl;
    localparam int LAT = 7, DW = 32, DEPTH = 8;

    logic          clk = 1'b0, clear_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0, rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [DW-1:0] add_a, add_b, add_res, rsp0_data, rsp1_data;

    int checks = 0, errors = 0, cyc = 0;
    int out0 = 0, out1 = 0, acc0 = 0, acc1 = 0, last_acc0_cyc = 0;
    logic model_last = 1'b1;
    logic [DW-1:0] q0[$], q1[$];
    logic [DW-1:0] apipe [LAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpadd_share_ctrl #(.LATENCY(LAT), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .clear_n(clear_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .add_a(add_a), .add_b(add_b), .add_res(add_res),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .busy(busy)
    );

    // Integer-valued single-precision helpers (exact for values below 2^24).
    function automatic logic [31:0] i2f(input int unsigned n);
        int p;
        logic [31:0] r;
        if (n == 0) return 32'h0;
        p = 31;
        while (n[p] == 1'b0) p--;
        r = 32'h0;
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'(n << (23 - p));
        return r;
    endfunction

    function automatic int unsigned f2i(input logic [31:0] f);
        int e;
        logic [31:0] m;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]) - 127;
        m = {9'h1, f[22:0]};
        return m >> (23 - e);
    endfunction

    // External adder model: LAT edges from capture to result, no reset, no stall.
    always @(posedge clk) begin
        apipe[0] <= i2f(f2i(add_a) + f2i(add_b));
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign add_res = apipe[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor + reference model: arbitration rule, credits, busy, operand steering, scoreboard.
    logic e0, e1, g0, g1;
    logic [DW-1:0] exp_a, exp_b, got;
    always @(negedge clk) begin
        if (!clear_n) begin
            check("reset_ctl", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, 64'h0);
            check("reset_add", {add_a, add_b}, 64'h0);
            q0.delete(); q1.delete();
            out0 = 0; out1 = 0; model_last = 1'b1;
        end else begin
            e0 = req0_valid && (out0 < DEPTH);
            e1 = req1_valid && (out1 < DEPTH);
            g0 = e0 && (!e1 || model_last);
            g1 = e1 && (!e0 || !model_last);
            check("grant", {req0_ready, req1_ready}, {g0, g1});
            check("busy", busy, (out0 + out1) != 0);
            exp_a = g0 ? req0_a : (g1 ? req1_a : '0);
            exp_b = g0 ? req0_b : (g1 ? req1_b : '0);
            check("add_ops", {add_a, add_b}, {exp_a, exp_b});
            if (rsp0_valid && q0.size() == 0) check("spurious_rsp0", rsp0_valid, 1'b0);
            if (rsp1_valid && q1.size() == 0) check("spurious_rsp1", rsp1_valid, 1'b0);
            if (rsp0_valid && rsp0_ready && q0.size() != 0) begin
                got = q0.pop_front(); check("rsp0_data", rsp0_data, got); out0--;
            end
            if (rsp1_valid && rsp1_ready && q1.size() != 0) begin
                got = q1.pop_front(); check("rsp1_data", rsp1_data, got); out1--;
            end
            if (g0) begin
                q0.push_back(i2f(f2i(req0_a) + f2i(req0_b)));
                out0++; acc0++; last_acc0_cyc = cyc; model_last = 1'b0;
            end
            if (g1) begin
                q1.push_back(i2f(f2i(req1_a) + f2i(req1_b)));
                out1++; acc1++; model_last = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic rand_ops();
        req0_a = i2f($urandom_range(0, 1 << 20)); req0_b = i2f($urandom_range(0, 1 << 20));
        req1_a = i2f($urandom_range(0, 1 << 20)); req1_b = i2f($urandom_range(0, 1 << 20));
    endtask

    task automatic drain(input int n);
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (n) tick();
        check("drained_q0", q0.size(), 0);
        check("drained_q1", q1.size(), 0);
    endtask

    int hs, a0, a1, k8;
    logic found;
    initial begin
        // 1: reset then a single op with latency measurement
        repeat (3) tick();
        clear_n = 1'b1;
        tick();
        req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000; rsp0_ready = 1'b1;
        @(negedge clk); hs = cyc;
        check("t1_accept", req0_ready, 1'b1);
        tick(); req0_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (rsp0_valid) begin
                found = 1'b1;
                check("t1_latency", cyc - hs, LAT + 1);
                check("t1_sum", rsp0_data, 32'h40400000);
            end
        end
        if (!found) check("t1_timeout", 1'b0, 1'b1);
        drain(12);

        // 2: contention, both streaming, responses always consumed
        a0 = acc0; a1 = acc1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin rand_ops(); tick(); end
        check("t2_share0", acc0 - a0, 20);
        check("t2_share1", acc1 - a1, 20);
        drain(20);

        // 3: backpressure on requester 0 until credits run out, then release
        a0 = acc0;
        rsp0_ready = 1'b0; req0_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin rand_ops(); tick(); end
        check("t3_credit_cap", acc0 - a0, DEPTH);
        @(negedge clk); check("t3_stalled", req0_ready, 1'b0);
        tick(); rsp0_ready = 1'b1;
        repeat (30) tick();
        check("t3_resumed", (acc0 - a0) > DEPTH, 1'b1);
        drain(20);

        // 4: req0 credit-stalled while req1 streams, then fully random traffic
        rsp0_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin rsp1_ready = ($urandom_range(0, 3) != 0); rand_ops(); tick(); end
        for (int k = 0; k < 250; k++) begin
            req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
            rsp0_ready = ($urandom_range(0, 3) != 0); rsp1_ready = 1'($urandom_range(0, 1));
            rand_ops(); tick();
        end
        drain(40);

        // 5: reset while ops are in flight; requests held valid during reset
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin rand_ops(); tick(); end
        clear_n = 1'b0;
        #1 check("t5_async_ready", {req0_ready, req1_ready, busy}, 64'h0);
        tick(); tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        clear_n = 1'b1;
        repeat (20) tick();
        check("t5_idle_busy", busy, 1'b0);

        // 6: push and pop in the same cycle with FIFO0 at occupancy 7
        a0 = acc0;
        rsp0_ready = 1'b0; req0_valid = 1'b1;
        for (int k = 0; k < 30 && (acc0 - a0) < DEPTH; k++) begin rand_ops(); tick(); end
        check("t6_filled", acc0 - a0, DEPTH);
        k8 = last_acc0_cyc;
        for (int k = 0; k < 30 && cyc < k8 + LAT; k++) tick();
        rsp0_ready = 1'b1;
        @(negedge clk);
        check("t6_occ7_valid", rsp0_valid, 1'b1);
        check("t6_no_credit", req0_ready, 1'b0);
        tick(); rsp0_ready = 1'b0;
        @(negedge clk);
        check("t6_credit_back", req0_ready, 1'b1);
        tick(); req0_valid = 1'b0;
        @(negedge clk);
        check("t6_queued", q0.size(), DEPTH);
        drain(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
